// File: rtl/booth_seq_mul.sv
// booth_seq_mul: sequential Booth multiplier with start/busy/done handshake.
//
// Operands are extended to WIDTH+2 bits (sign- or zero-extended according to
// is_signed) so a single two's-complement Booth datapath serves both modes.
// The product is truncated to 2*WIDTH bits, which is exact in both modes.
//
// Build option: define BOOTH_RADIX4_EN for radix-4 recoding, which takes
// WIDTH/2+1 iterations. By default, radix-2 recoding takes WIDTH+1 iterations.
// Ports, handshake and results are the same in both builds.
//
// Parameters:
//   WIDTH         operand width in bits (even, 4..32)
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   start         request, sampled only in idle
//   is_signed     1 = two's-complement operands, 0 = unsigned; captured with start
//   multiplicand  operand A; captured with start
//   multiplier    operand B; captured with start
//   busy          high while calculating and during the done cycle
//   done          one-cycle completion pulse
//   result        2*WIDTH-bit product, held until the next completion
module booth_seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  // Extended operand width, and the accumulator width. Two guard bits above the
  // extended operand keep the running sum (up to +/-2A in radix-4) from
  // overflowing before the arithmetic shift.
  localparam int unsigned XW = WIDTH + 2;
  localparam int unsigned HW = WIDTH + 4;

`ifdef BOOTH_RADIX4_EN
  localparam int unsigned Shift = 2;
  localparam int unsigned Iter  = WIDTH / 2 + 1;
`else
  localparam int unsigned Shift = 1;
  localparam int unsigned Iter  = WIDTH + 1;
`endif

  // The scanned multiplier bits leave the bottom of lo. After the last shift,
  // the product starts at bit Off of {hi, lo}. Bits below Off are unscanned
  // multiplier bits: bit 0 in radix-2, and none in radix-4.
  localparam int unsigned Off = XW - Iter * Shift;
  localparam int unsigned CW  = $clog2(Iter + 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [XW-1:0]      mcand_q;
  logic [HW-1:0]      hi_q;
  logic [XW-1:0]      lo_q;
  logic               qm1_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] result_q;

  logic                      last_iter;
  logic [HW-1:0]             mcand_hw;
  logic [HW-1:0]             addend;
  logic [HW-1:0]             sum;
  logic signed [HW+XW-1:0]   comb_s;
  logic signed [HW+XW-1:0]   shifted;
  logic [2*WIDTH-1:0]        result_nxt;
  logic [XW-1:0]             mcand_ext;
  logic [XW-1:0]             mplier_ext;

  assign last_iter = (cnt_q == CW'(Iter - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCalc;
      StCalc:  if (last_iter) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy   = (state_q == StCalc) || (state_q == StDone);
    done   = (state_q == StDone);
    result = result_q;
  end

  // ---------------------------------------------------------------------------
  // Booth recoding and one shift-add step
  // ---------------------------------------------------------------------------
  always_comb begin
    mcand_ext  = is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                           : {2'b00, multiplicand};
    mplier_ext = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier}
                           : {2'b00, multiplier};
  end

  always_comb begin
    mcand_hw = {{(HW - XW){mcand_q[XW-1]}}, mcand_q};
    addend   = '0;
`ifdef BOOTH_RADIX4_EN
    case ({lo_q[1:0], qm1_q})
      3'b001, 3'b010: addend = mcand_hw;
      3'b011:         addend = {mcand_hw[HW-2:0], 1'b0};
      3'b100:         addend = -{mcand_hw[HW-2:0], 1'b0};
      3'b101, 3'b110: addend = -mcand_hw;
      default:        addend = '0;
    endcase
`else
    case ({lo_q[0], qm1_q})
      2'b01:   addend = mcand_hw;
      2'b10:   addend = -mcand_hw;
      default: addend = '0;
    endcase
`endif
    sum        = hi_q + addend;
    comb_s     = {sum, lo_q};
    shifted    = comb_s >>> Shift;
    result_nxt = shifted[Off +: 2*WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mcand_q <= mcand_ext;
            lo_q    <= mplier_ext;
            hi_q    <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        StCalc: begin
          hi_q  <= shifted[HW+XW-1:XW];
          lo_q  <= shifted[XW-1:0];
          qm1_q <= lo_q[Shift-1];
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            result_q <= result_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mul.sv
// Directed bench for booth_seq_mul. It uses three instances (WIDTH = 8, 4 and 32),
// which share the clock, reset and operand buses.
module tb_booth_seq_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        st8, st4, st32;
  logic        sgn;
  logic [31:0] a, b;

  logic        busy8, done8, busy4, done4, busy32, done32;
  logic [15:0] res8;
  logic [7:0]  res4;
  logic [63:0] res32;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_seq_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .is_signed(sgn),
    .multiplicand(a[7:0]), .multiplier(b[7:0]),
    .busy(busy8), .done(done8), .result(res8)
  );

  booth_seq_mul #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .is_signed(sgn),
    .multiplicand(a[3:0]), .multiplier(b[3:0]),
    .busy(busy4), .done(done4), .result(res4)
  );

  booth_seq_mul #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(st32), .is_signed(sgn),
    .multiplicand(a), .multiplier(b),
    .busy(busy32), .done(done32), .result(res32)
  );

  function automatic int iter_of(input int w);
`ifdef BOOTH_RADIX4_EN
    return w / 2 + 1;
`else
    return w + 1;
`endif
  endfunction

  function automatic logic cur_done(input int which);
    case (which)
      0:       return done8;
      1:       return done4;
      default: return done32;
    endcase
  endfunction

  function automatic logic cur_busy(input int which);
    case (which)
      0:       return busy8;
      1:       return busy4;
      default: return busy32;
    endcase
  endfunction

  function automatic logic [63:0] cur_res(input int which);
    case (which)
      0:       return {48'd0, res8};
      1:       return {56'd0, res4};
      default: return res32;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete operation on the selected instance. It checks latency,
  // the product, and the handshake.
  task automatic op(input int which, input logic [31:0] av, input logic [31:0] bv,
                    input logic s, input logic [63:0] exp, input string tag);
    int w;
    int cyc;
    bit seen;
    w = (which == 0) ? 8 : (which == 1) ? 4 : 32;
    @(negedge clk);
    a = av; b = bv; sgn = s;
    case (which)
      0:       st8 = 1'b1;
      1:       st4 = 1'b1;
      default: st32 = 1'b1;
    endcase
    @(posedge clk); #1;
    st8 = 1'b0; st4 = 1'b0; st32 = 1'b0;
    chk({tag, " busy_rise"}, 64'(cur_busy(which)), 64'd1);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cur_done(which)) seen = 1'b1;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(iter_of(w)));
    chk({tag, " result"}, cur_res(which), exp);
    @(posedge clk); #1;
    chk({tag, " done_fall"}, 64'(cur_done(which)), 64'd0);
    chk({tag, " busy_fall"}, 64'(cur_busy(which)), 64'd0);
  endtask

  initial begin
    int cyc;
    int d1, d2, ndone;
    bit seen;

    rst = 1'b1; st8 = 1'b0; st4 = 1'b0; st32 = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy8), 64'd0);
    chk("reset done", 64'(done8), 64'd0);
    chk("reset result", 64'(res8), 64'd0);
    rst = 1'b0;

    // Signed corners
    op(0, 32'hF9, 32'hFB, 1'b1, 64'h0023, "s -7x-5");
    op(0, 32'h03, 32'hFA, 1'b1, 64'hFFEE, "s 3x-6");
    op(0, 32'h80, 32'h80, 1'b1, 64'h4000, "s -128x-128");
    op(0, 32'h80, 32'h7F, 1'b1, 64'hC080, "s -128x127");

    // Reset while CALC is running for 5x3
    @(negedge clk);
    a = 32'd5; b = 32'd3; sgn = 1'b1; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", 64'(busy8), 64'd0);
    chk("midrst done", 64'(done8), 64'd0);
    chk("midrst result", 64'(res8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    op(0, 32'd5, 32'd3, 1'b1, 64'h000F, "s 5x3 after rst");

    // Unsigned operands, and the same bit patterns as signed
    op(0, 32'hFF, 32'hFF, 1'b0, 64'hFE01, "u 255x255");
    op(0, 32'hC8, 32'h03, 1'b0, 64'h0258, "u 200x3");
    op(0, 32'hFF, 32'hFF, 1'b1, 64'h0001, "s 0xFFx0xFF");
    op(0, 32'hC8, 32'h03, 1'b1, 64'hFF58, "s 0xC8x3");

    // Start pulsed during CALC with other operands is ignored
    @(negedge clk);
    a = 32'h03; b = 32'hFA; sgn = 1'b1; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 3) begin a = 32'h11; b = 32'h22; st8 = 1'b1; end
      if (cyc == 4) st8 = 1'b0;
      if (done8) seen = 1'b1;
    end
    chk("ign latency", 64'(cyc), 64'(iter_of(8)));
    chk("ign result", 64'(res8), 64'hFFEE);
    chk("ign busy_in_done", 64'(busy8), 64'd1);
    ndone = 0;
    for (int i = 0; i < iter_of(8) + 3; i++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    chk("ign single_pulse", 64'(ndone), 64'd0);
    chk("hold result", 64'(res8), 64'hFFEE);
    chk("hold idle busy", 64'(busy8), 64'd0);

    // Back-to-back with start held high: 6x-1, then 0x6
    @(negedge clk);
    a = 32'h06; b = 32'hFF; sgn = 1'b1; st8 = 1'b1;
    @(posedge clk); #1;
    a = 32'h00; b = 32'h06;
    cyc = 0; d1 = -1; d2 = -1;
    while (d2 < 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done8) begin
        if (d1 < 0) begin
          d1 = cyc;
          chk("b2b first result", 64'(res8), 64'hFFFA);
        end else begin
          d2 = cyc;
          st8 = 1'b0;
          chk("b2b second result", 64'(res8), 64'h0000);
        end
      end
    end
    chk("b2b first latency", 64'(d1), 64'(iter_of(8)));
    chk("b2b interval", 64'(d2 - d1), 64'(iter_of(8) + 2));
    repeat (3) @(posedge clk);
    #1;
    chk("b2b idle after", 64'(busy8), 64'd0);

    // Width sweep
    op(1, 32'h7, 32'h1, 1'b1, 64'h07, "w4 7x1");
    op(1, 32'h8, 32'h8, 1'b1, 64'h40, "w4 -8x-8");
    op(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, "w32 unsigned");
    op(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, "w32 signed");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
